// File: rtl/ebc_event_arbiter_ctrl.sv
// Event arbiter between the pixel array and the event readout: row then column
// round-robin grant, timestamped event word over valid/ready, one-cycle pixel ack.
module ebc_event_arbiter_ctrl #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int POLARITY = 2,
  parameter int ROW_ADD  = 3,
  parameter int COL_ADD  = 3,
  parameter int SIZE     = 32,
  parameter int WIDTH    = 39
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic [ROWS*COLS*POLARITY-1:0] pix_req_i,
  output logic [ROWS*COLS*POLARITY-1:0] pix_ack_o,
  output logic                         evt_valid_o,
  input  logic                         evt_ready_i,
  output logic [WIDTH-1:0]             evt_data_o,
  output logic                         busy_o
);

  // state   | meaning
  // IDLE    | wait for enable and any request, grant a row
  // COL_SEL | re-sample granted row, grant column/polarity, stamp event
  // SEND    | present event word until downstream accepts it
  // ACK     | one-cycle acknowledge to the granted request bit
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COL_SEL = 2'd1;
  localparam logic [1:0] SEND    = 2'd2;
  localparam logic [1:0] ACK     = 2'd3;

  localparam int ROW_BITS = COLS * POLARITY;
  localparam int NREQ     = ROWS * COLS * POLARITY;

  if (WIDTH != SIZE + ROW_ADD + COL_ADD + 1) begin : g_width_check
    $error("ebc_event_arbiter_ctrl: WIDTH must equal SIZE+ROW_ADD+COL_ADD+1");
  end

  logic [1:0]          state_q;
  logic [SIZE-1:0]     ts_q;
  logic [ROW_ADD-1:0]  row_ptr_q;
  logic [COL_ADD-1:0]  col_ptr_q [ROWS];
  logic [ROW_ADD-1:0]  row_q;
  logic [COL_ADD-1:0]  col_q;
  logic                pol_q;
  logic [WIDTH-1:0]    data_q;
  logic                valid_q;
  logic [NREQ-1:0]     ack_q;

  logic [ROWS-1:0]     row_any;
  logic                row_hit;
  logic [ROW_ADD-1:0]  row_sel;
  logic [ROW_BITS-1:0] row_req;
  logic [COLS-1:0]     col_any;
  logic                col_hit;
  logic [COL_ADD-1:0]  col_sel;
  logic                pol_sel;
  logic [COL_ADD-1:0]  col_base;
  logic [ROW_ADD-1:0]  next_row;
  logic [COL_ADD-1:0]  next_col;
  int                  ack_idx;

  always_comb begin
    row_any = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_any[r] = |pix_req_i[r*ROW_BITS +: ROW_BITS];
    end
  end

  always_comb begin
    row_hit = 1'b0;
    row_sel = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!row_hit && row_any[(int'(row_ptr_q) + i) % ROWS]) begin
        row_hit = 1'b1;
        row_sel = ROW_ADD'((int'(row_ptr_q) + i) % ROWS);
      end
    end
  end

  // Live requests of the latched row; withdrawn requests simply vanish here.
  assign row_req  = pix_req_i[int'(row_q)*ROW_BITS +: ROW_BITS];
  assign col_base = col_ptr_q[row_q];

  always_comb begin
    col_any = '0;
    for (int c = 0; c < COLS; c++) begin
      col_any[c] = |row_req[c*POLARITY +: POLARITY];
    end
  end

  always_comb begin
    col_hit = 1'b0;
    col_sel = '0;
    for (int i = 0; i < COLS; i++) begin
      if (!col_hit && col_any[(int'(col_base) + i) % COLS]) begin
        col_hit = 1'b1;
        col_sel = COL_ADD'((int'(col_base) + i) % COLS);
      end
    end
  end

  // ON (top polarity bit) wins when both polarities are pending.
  assign pol_sel  = row_req[int'(col_sel)*POLARITY + POLARITY - 1];
  assign next_row = (row_q == ROW_ADD'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign next_col = (col_q == COL_ADD'(COLS - 1)) ? '0 : col_q + 1'b1;
  assign ack_idx  = (int'(row_q) * COLS + int'(col_q)) * POLARITY + int'(pol_q);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      ts_q      <= '0;
      row_ptr_q <= '0;
      for (int r = 0; r < ROWS; r++) begin
        col_ptr_q[r] <= '0;
      end
      row_q     <= '0;
      col_q     <= '0;
      pol_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ack_q     <= '0;
    end else begin
      ts_q  <= ts_q + SIZE'(1);
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (en_i && row_hit) begin
            row_q   <= row_sel;
            state_q <= COL_SEL;
          end
        end
        COL_SEL: begin
          if (col_hit) begin
            col_q   <= col_sel;
            pol_q   <= pol_sel;
            data_q  <= {ts_q, row_q, col_sel, pol_sel};
            valid_q <= 1'b1;
            state_q <= SEND;
          end else begin
            state_q <= IDLE;
          end
        end
        SEND: begin
          if (valid_q && evt_ready_i) begin
            valid_q             <= 1'b0;
            ack_q[ack_idx]      <= 1'b1;
            row_ptr_q           <= next_row;
            col_ptr_q[row_q]    <= next_col;
            state_q             <= ACK;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pix_ack_o   = ack_q;
  assign evt_valid_o = valid_q;
  assign evt_data_o  = data_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_ebc_event_arbiter_ctrl.sv
// Bench for ebc_event_arbiter_ctrl: transaction-level round-robin reference model,
// plus a narrow-timestamp copy of the design sharing all inputs to exercise wrap.
module tb_ebc_event_arbiter_ctrl;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [127:0] pix_req;
  logic [127:0] pix_ack;
  logic         evt_valid;
  logic         evt_ready;
  logic [38:0]  evt_data;
  logic         busy;
  logic [127:0] w_ack;
  logic         w_valid;
  logic [10:0]  w_data;
  logic         w_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] ts_model;
  int          row_ptr;
  int          col_ptr [8];

  ebc_event_arbiter_ctrl dut (
    .clk_i(clk), .reset_i(rst_n), .en_i(en), .pix_req_i(pix_req),
    .pix_ack_o(pix_ack), .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
    .evt_data_o(evt_data), .busy_o(busy)
  );

  ebc_event_arbiter_ctrl #(.SIZE(4), .WIDTH(11)) dut_w (
    .clk_i(clk), .reset_i(rst_n), .en_i(en), .pix_req_i(pix_req),
    .pix_ack_o(w_ack), .evt_valid_o(w_valid), .evt_ready_i(evt_ready),
    .evt_data_o(w_data), .busy_o(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running timestamp as the number of clock edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_model <= 32'd0;
    else        ts_model <= ts_model + 32'd1;
  end

  task automatic reset_model();
    row_ptr = 0;
    for (int i = 0; i < 8; i++) col_ptr[i] = 0;
  endtask

  function automatic void predict(input logic [127:0] req, output bit hit,
                                  output int r, output int c, output int p);
    hit = 0; r = 0; c = 0; p = 0;
    for (int i = 0; i < 8 && !hit; i++) begin
      int rr;
      rr = (row_ptr + i) % 8;
      if (req[rr*16 +: 16] != 16'd0) begin
        hit = 1;
        r = rr;
        for (int j = 0; j < 8; j++) begin
          int cc;
          cc = (col_ptr[rr] + j) % 8;
          if (req[(rr*8+cc)*2 +: 2] != 2'b00) begin
            c = cc;
            p = req[(rr*8+cc)*2+1] ? 1 : 0;
            break;
          end
        end
      end
    end
  endfunction

  function automatic logic [127:0] gen_req();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < int'($urandom_range(1, 4)); i++) v[$urandom_range(0, 127)] = 1'b1;
    return v;
  endfunction

  // Called just after a falling edge with the design idle and pix_req already applied.
  task automatic do_event(input int delay, input bit drop, input bit en_off);
    bit hit; int r, c, p, idx;
    logic [31:0]  t;
    logic [38:0]  exp_d;
    logic [10:0]  exp_w;
    logic [127:0] exp_ack;
    predict(pix_req, hit, r, c, p);
    t     = ts_model + 32'd1;
    exp_d = {t, 3'(r), 3'(c), 1'(p)};
    exp_w = {t[3:0], 3'(r), 3'(c), 1'(p)};
    idx   = (r*8 + c)*2 + p;
    exp_ack = '0;
    exp_ack[idx] = 1'b1;
    evt_ready = (delay == 0);
    total_cnt++;
    if (!hit) $display("FAIL ev_setup: model found no request, req=%h", pix_req);
    else pass_cnt++;
    @(negedge clk);
    if (en_off) en = 1'b0;
    total_cnt++;
    if ({evt_valid, busy} !== 2'b01) $display("FAIL ev_colsel: valid,busy=%b expected 01", {evt_valid, busy});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (evt_valid !== 1'b1 || w_valid !== 1'b1 || evt_data !== exp_d || w_data !== exp_w)
      $display("FAIL ev_data: valid=%b data=%h wdata=%h expected data=%h wdata=%h",
               evt_valid, evt_data, w_data, exp_d, exp_w);
    else pass_cnt++;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      total_cnt++;
      if (evt_valid !== 1'b1 || evt_data !== exp_d || pix_ack !== '0)
        $display("FAIL ev_hold: valid=%b data=%h ack=%h expected data=%h no ack",
                 evt_valid, evt_data, pix_ack, exp_d);
      else pass_cnt++;
    end
    evt_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (pix_ack !== exp_ack || w_ack !== exp_ack || evt_valid !== 1'b0)
      $display("FAIL ev_ack: ack=%h valid=%b expected ack=%h valid=0", pix_ack, evt_valid, exp_ack);
    else pass_cnt++;
    if (drop) pix_req[idx] = 1'b0;
    row_ptr    = (r + 1) % 8;
    col_ptr[r] = (c + 1) % 8;
    en = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (pix_ack !== '0 || busy !== 1'b0 || w_busy !== 1'b0)
      $display("FAIL ev_idle: ack=%h busy=%b expected ack=0 busy=0", pix_ack, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; evt_ready = 1'b0; pix_req = '0;
    reset_model();
    #2;
    total_cnt++;
    if (pix_ack !== '0 || evt_valid !== 1'b0 || evt_data !== '0 || busy !== 1'b0 ||
        w_ack !== '0 || w_valid !== 1'b0 || w_data !== '0 || w_busy !== 1'b0)
      $display("FAIL reset_vals: ack=%h valid=%b data=%h busy=%b expected all zero",
               pix_ack, evt_valid, evt_data, busy);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || evt_valid !== 1'b0)
      $display("FAIL reset_idle: busy=%b valid=%b expected 0 0", busy, evt_valid);
    else pass_cnt++;
  endtask

  task automatic test_single();
    pix_req = '0;
    pix_req[(2*8+5)*2+1] = 1'b1;
    do_event(0, 1, 0);
  endtask

  task automatic test_round_robin();
    pix_req = '0;
    pix_req[(0*8+1)*2+0] = 1'b1;
    pix_req[(0*8+6)*2+0] = 1'b1;
    pix_req[(4*8+3)*2+1] = 1'b1;
    for (int i = 0; i < 6; i++) do_event(0, 0, 0);
    pix_req = '0;
  endtask

  task automatic test_dual_pol();
    pix_req = '0;
    pix_req[127] = 1'b1;
    pix_req[126] = 1'b1;
    do_event(0, 1, 0);
    do_event(0, 1, 0);
    pix_req = '0;
  endtask

  task automatic test_back_pressure();
    pix_req = gen_req();
    do_event(10, 1, 0);
    pix_req = '0;
  endtask

  task automatic test_withdraw();
    pix_req = gen_req();
    @(negedge clk);
    pix_req = '0;
    @(negedge clk);
    total_cnt++;
    if (evt_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL withdraw: valid=%b busy=%b expected 0 0", evt_valid, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (pix_ack !== '0) $display("FAIL withdraw_ack: ack=%h expected 0", pix_ack);
    else pass_cnt++;
    pix_req = gen_req();
    do_event(0, 1, 0);
    pix_req = '0;
  endtask

  task automatic test_enable();
    en = 1'b0;
    pix_req = gen_req();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total_cnt++;
      if (busy !== 1'b0 || evt_valid !== 1'b0)
        $display("FAIL en_block: busy=%b valid=%b expected 0 0", busy, evt_valid);
      else pass_cnt++;
    end
    en = 1'b1;
    do_event(1, 1, 1);
    pix_req = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      pix_req = gen_req();
      do_event(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    pix_req = '0;
  endtask

  task automatic test_ts_wrap();
    pix_req = '0;
    pix_req[(3*8+0)*2+0] = 1'b1;
    for (int n = 0; n < 9; n++) do_event(0, 0, 0);
    pix_req = '0;
  endtask

  task automatic test_reset_mid();
    pix_req = gen_req();
    evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (evt_valid !== 1'b1) $display("FAIL rmid_send: valid=%b expected 1", evt_valid);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (evt_valid !== 1'b0 || busy !== 1'b0 || pix_ack !== '0 || evt_data !== '0)
      $display("FAIL rmid_drop: valid=%b busy=%b ack=%h data=%h expected all zero",
               evt_valid, busy, pix_ack, evt_data);
    else pass_cnt++;
    pix_req = '0;
    evt_ready = 1'b1;
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if (pix_ack !== '0 || busy !== 1'b0)
        $display("FAIL rmid_noack: ack=%h busy=%b expected 0 0", pix_ack, busy);
      else pass_cnt++;
    end
    test_single();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_dual_pol();
    test_back_pressure();
    test_withdraw();
    test_enable();
    test_random();
    test_ts_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
